// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size and FSM
// state encodings, plus the alignment rule used at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // True when an access of this size cannot be issued at this address.
    // A dword access is only meaningful on a 64-bit datapath.
    function automatic logic lsu_misaligned(input lsu_size_e size,
                                            input logic [2:0] addr_lo,
                                            input logic dword_ok);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = !dword_ok || (|addr_lo);
        endcase
        return mis;
    endfunction

    // Number of data bits carried by an access of the given size.
    function automatic logic [6:0] lsu_size_bits(input lsu_size_e size);
        return 7'd8 << size;
    endfunction

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] lsu_size_bytes(input lsu_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering. Store side: trims the right-justified store
// data to the access size, shifts it into the addressed byte lane and builds
// the byte enables. Load side: shifts the addressed lane down to bit 0,
// truncates to the access size and sign/zero-extends.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  lsu_size_e              st_size_i,
    input  logic [OFF_W-1:0]       st_off_i,
    input  logic [DATA_W-1:0]      st_wdata_i,
    output logic [DATA_W-1:0]      st_wdata_o,
    output logic [DATA_W/8-1:0]    st_be_o,
    input  lsu_size_e              ld_size_i,
    input  logic [OFF_W-1:0]       ld_off_i,
    input  logic                   ld_sext_i,
    input  logic [DATA_W-1:0]      ld_rdata_i,
    output logic [DATA_W-1:0]      ld_data_o
);

    localparam int NB = DATA_W / 8;

    logic [6:0]        st_bits;
    logic [6:0]        ld_bits;
    logic [3:0]        st_bytes;
    logic [3:0]        st_off_ext;
    logic [DATA_W-1:0] st_masked;
    logic [DATA_W-1:0] ld_shifted;
    logic              ld_msb;

    assign st_bits    = lsu_size_bits(st_size_i);
    assign ld_bits    = lsu_size_bits(ld_size_i);
    assign st_bytes   = lsu_size_bytes(st_size_i);
    assign st_off_ext = 4'(st_off_i);

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    assign st_wdata_o = st_masked << {st_off_i, 3'b000};

    // Sign bit of the loaded item sits at the top of its size window.
    always_comb begin
        case (ld_size_i)
            SZ_B:    ld_msb = ld_shifted[7];
            SZ_H:    ld_msb = ld_shifted[15];
            SZ_W:    ld_msb = ld_shifted[31];
            default: ld_msb = ld_shifted[DATA_W-1];
        endcase
    end

    // Per-bit size trimming for stores and truncate/extend for loads.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign st_masked[gi] = (7'(gi) < st_bits) ? st_wdata_i[gi] : 1'b0;
            assign ld_data_o[gi] = (7'(gi) < ld_bits) ? ld_shifted[gi]
                                                      : (ld_sext_i & ld_msb);
        end
    endgenerate

    // A lane is enabled when it falls inside [offset, offset + bytes).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_be
            assign st_be_o[gi] = (4'(gi) >= st_off_ext) &&
                                 (4'(gi) < (st_off_ext + st_bytes));
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit between the pipeline and a req/gnt/rvalid data
// memory port. Misaligned or illegal-size accesses complete with a fault
// without touching the bus; bus errors and response timeouts complete with
// o_bus_err. All bus-side and completion outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_we,
    input  logic [1:0]          i_size,
    input  logic                i_sign_ext,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_done,
    output logic                o_misaligned,
    output logic                o_bus_err,
    output logic                o_stall,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    lsu_state_e         state_q;
    lsu_size_e          size_q;
    logic [OFF_W-1:0]   off_q;
    logic               sext_q;
    logic               we_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [NB-1:0]      mem_be_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               done_q;
    logic               mis_q;
    logic               bus_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    lsu_size_e          acc_size;
    logic [OFF_W-1:0]   acc_off;
    logic               acc_mis;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  st_wdata;
    logic [NB-1:0]      st_be;
    logic [DATA_W-1:0]  ld_data;

    assign acc_size = lsu_size_e'(i_size);
    assign acc_off  = i_addr[OFF_W-1:0];
    assign acc_mis  = lsu_misaligned(acc_size, i_addr[2:0], DATA_W == 64);
    assign acc_addr = i_addr & ~ADDR_W'(NB - 1);
    assign cnt_d    = cnt_q + 1'b1;

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_size_i  (acc_size),
        .st_off_i   (acc_off),
        .st_wdata_i (i_wdata),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be),
        .ld_size_i  (size_q),
        .ld_off_i   (off_q),
        .ld_sext_i  (sext_q),
        .ld_rdata_i (i_mem_rdata),
        .ld_data_o  (ld_data)
    );

    // Stall covers the bus phases and the cycle an aligned access is taken.
    assign o_ready      = (state_q == IDLE);
    assign o_stall      = (state_q == REQ) || (state_q == RESP) ||
                          ((state_q == IDLE) && i_valid && !acc_mis);
    assign o_rdata      = rdata_q;
    assign o_done       = done_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = bus_err_q;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_be     = mem_be_q;

    // Transaction FSM with registered bus and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_B;
            off_q       <= '0;
            sext_q      <= 1'b0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        size_q <= acc_size;
                        off_q  <= acc_off;
                        sext_q <= i_sign_ext;
                        we_q   <= i_we;
                        if (acc_mis) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= i_we;
                            mem_addr_q  <= acc_addr;
                            mem_be_q    <= st_be;
                            mem_wdata_q <= st_wdata;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= '0;
                    if (i_mem_gnt) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        bus_err_q <= i_mem_err;
                        if (!we_q && !i_mem_err) begin
                            rdata_q <= ld_data;
                        end
                    end else if ((TIMEOUT_CYC != 0) && (cnt_d == TIMEOUT_VAL)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance with a short timeout and a
// 64-bit instance with the timeout disabled share stimulus; a table of
// directed vectors, a mid-transaction reset and random transactions checked
// against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid32, valid64;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        we, sext;
    logic [1:0]  size;
    logic        gnt, rvalid, merr;
    logic [63:0] mrdata;
    bit          sel64;

    logic        ready32, done32, mis32, berr32, stall32, req32, mwe32;
    logic [31:0] maddr32, mwdata32, rdata32;
    logic [3:0]  be32;
    logic        ready64, done64, mis64, berr64, stall64, req64, mwe64;
    logic [31:0] maddr64;
    logic [63:0] mwdata64, rdata64;
    logic [7:0]  be64;

    logic        x_ready, x_done, x_mis, x_berr, x_stall, x_req, x_we;
    logic [31:0] x_addr;
    logic [63:0] x_wdata, x_rdata;
    logic [7:0]  x_be;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] prev32 = 64'd0;
    logic [63:0] prev64 = 64'd0;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid32), .o_ready(ready32),
        .i_addr(addr), .i_wdata(wdata[31:0]), .i_we(we), .i_size(size),
        .i_sign_ext(sext), .o_rdata(rdata32), .o_done(done32),
        .o_misaligned(mis32), .o_bus_err(berr32), .o_stall(stall32),
        .o_mem_req(req32), .o_mem_we(mwe32), .o_mem_addr(maddr32),
        .o_mem_wdata(mwdata32), .o_mem_be(be32), .i_mem_gnt(gnt),
        .i_mem_rvalid(rvalid), .i_mem_rdata(mrdata[31:0]), .i_mem_err(merr)
    );

    load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid64), .o_ready(ready64),
        .i_addr(addr), .i_wdata(wdata), .i_we(we), .i_size(size),
        .i_sign_ext(sext), .o_rdata(rdata64), .o_done(done64),
        .o_misaligned(mis64), .o_bus_err(berr64), .o_stall(stall64),
        .o_mem_req(req64), .o_mem_we(mwe64), .o_mem_addr(maddr64),
        .o_mem_wdata(mwdata64), .o_mem_be(be64), .i_mem_gnt(gnt),
        .i_mem_rvalid(rvalid), .i_mem_rdata(mrdata), .i_mem_err(merr)
    );

    // Route the selected instance to a common set of observation signals.
    always_comb begin
        if (sel64) begin
            x_ready = ready64; x_done = done64; x_mis = mis64; x_berr = berr64;
            x_stall = stall64; x_req = req64; x_we = mwe64; x_addr = maddr64;
            x_wdata = mwdata64; x_rdata = rdata64; x_be = be64;
        end else begin
            x_ready = ready32; x_done = done32; x_mis = mis32; x_berr = berr32;
            x_stall = stall32; x_req = req32; x_we = mwe32; x_addr = maddr32;
            x_wdata = {32'd0, mwdata32}; x_rdata = {32'd0, rdata32};
            x_be = {4'd0, be32};
        end
    end

    task automatic chk1(input string nm, input string f, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0b expected %0b", nm, f, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz, input int nb);
        int align;
        if (sz == 2'd3 && nb == 4) return 1'b1;
        align = 1 << sz;
        return (a % 32'(align)) != 32'd0;
    endfunction

    function automatic logic [7:0] m_be(input logic [31:0] a, input logic [1:0] sz, input int nb);
        int nbytes;
        int off;
        nbytes = 1 << sz;
        off = int'(a % 32'(nb));
        return 8'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [31:0] a,
                                            input logic [1:0] sz, input int nb);
        int bits;
        int off;
        logic [63:0] v;
        bits = 8 << sz;
        off = int'(a % 32'(nb));
        v = wd;
        if (bits < 64) v = v & ((64'd1 << bits) - 64'd1);
        v = v << (8 * off);
        if (nb == 4) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sx, input int nb);
        int bits;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        bits = 8 << sz;
        off = int'(a % 32'(nb));
        v = rd;
        if (nb == 4) v = v & 64'hFFFF_FFFF;
        v = v >> (8 * off);
        mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        v = v & mask;
        if (sx && v[bits-1]) v = v | ~mask;
        if (nb == 4) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] be_bits(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Outputs of the selected instance in its reset/idle state.
    task automatic chk_reset(input string nm);
        chk1(nm, "ready", x_ready, 1'b1);
        chk1(nm, "done", x_done, 1'b0);
        chk1(nm, "mis", x_mis, 1'b0);
        chk1(nm, "berr", x_berr, 1'b0);
        chk1(nm, "stall", x_stall, 1'b0);
        chk1(nm, "req", x_req, 1'b0);
        chk1(nm, "we", x_we, 1'b0);
        chk64(nm, "addr", 64'(x_addr), 64'd0);
        chk64(nm, "wdata", x_wdata, 64'd0);
        chk64(nm, "be", 64'(x_be), 64'd0);
        chk64(nm, "rdata", x_rdata, 64'd0);
    endtask

    // One complete access. gd = REQ cycles before gnt; rvd = RESP cycle index
    // carrying rvalid (-1 = never). Starts and ends at a falling edge.
    task automatic run_txn(input bit d64, input logic [31:0] a, input logic [63:0] wd,
                           input bit w, input logic [1:0] sz, input bit sx, input int gd,
                           input int rvd, input bit er, input logic [63:0] rd,
                           input bit e_mis, input logic [7:0] e_be, input bit e_err,
                           input logic [63:0] e_rdata, input string nm);
        int to;
        int nb;
        bit fin;
        logic [63:0] bmask;
        logic [63:0] e_wd;
        to = d64 ? 0 : 4;
        nb = d64 ? 8 : 4;
        sel64 = d64;
        addr = a; wdata = wd; we = w; size = sz; sext = sx; mrdata = rd; merr = er;
        if (d64) valid64 = 1'b1; else valid32 = 1'b1;
        #1;
        chk1(nm, "acc_ready", x_ready, 1'b1);
        chk1(nm, "acc_stall", x_stall, !e_mis);
        tick();
        valid32 = 1'b0; valid64 = 1'b0;
        #1;
        if (e_mis) begin
            chk1(nm, "mis_done", x_done, 1'b1);
            chk1(nm, "mis_flag", x_mis, 1'b1);
            chk1(nm, "mis_berr", x_berr, 1'b0);
            chk1(nm, "mis_req", x_req, 1'b0);
            chk1(nm, "mis_stall", x_stall, 1'b0);
            chk1(nm, "mis_ready", x_ready, 1'b0);
            chk64(nm, "mis_rdata", x_rdata, e_rdata);
        end else begin
            e_wd = m_wdata(wd, a, sz, nb);
            bmask = be_bits(e_be);
            for (int k = 0; k <= gd; k++) begin
                chk1(nm, "req", x_req, 1'b1);
                chk1(nm, "req_we", x_we, w);
                chk64(nm, "req_addr", 64'(x_addr), 64'(a & ~32'(nb - 1)));
                chk64(nm, "req_be", 64'(x_be), 64'(e_be));
                chk64(nm, "req_wdata", x_wdata & bmask, e_wd & bmask);
                chk1(nm, "req_stall", x_stall, 1'b1);
                chk1(nm, "req_ready", x_ready, 1'b0);
                if (k < gd) rvalid = 1'b1;
                else gnt = 1'b1;
                tick();
                gnt = 1'b0; rvalid = 1'b0;
                #1;
            end
            fin = 1'b0;
            for (int i = 0; i < 40 && !fin; i++) begin
                chk1(nm, "resp_req", x_req, 1'b0);
                chk1(nm, "resp_stall", x_stall, 1'b1);
                chk1(nm, "resp_done", x_done, 1'b0);
                if (i == rvd) rvalid = 1'b1;
                tick();
                rvalid = 1'b0;
                #1;
                if (i == rvd) fin = 1'b1;
                else if (to != 0 && i == to - 1) fin = 1'b1;
            end
            chk1(nm, "resp_bound", fin, 1'b1);
            chk1(nm, "done", x_done, 1'b1);
            chk1(nm, "done_mis", x_mis, 1'b0);
            chk1(nm, "done_berr", x_berr, e_err);
            chk1(nm, "done_stall", x_stall, 1'b0);
            chk1(nm, "done_ready", x_ready, 1'b0);
            chk64(nm, "done_rdata", x_rdata, e_rdata);
        end
        tick();
        #1;
        chk1(nm, "post_done", x_done, 1'b0);
        chk1(nm, "post_ready", x_ready, 1'b1);
        if (d64) prev64 = e_rdata; else prev32 = e_rdata;
        $display("txn %s d64=%0d addr=0x%0h size=%0d we=%0d rdata=0x%0h errors=%0d",
                 nm, d64, a, sz, w, x_rdata, n_errors);
    endtask

    typedef struct {
        bit          d64;
        logic [31:0] a;
        logic [63:0] wd;
        bit          w;
        logic [1:0]  sz;
        bit          sx;
        int          gd;
        int          rvd;
        bit          er;
        logic [63:0] rd;
        bit          e_mis;
        logic [7:0]  e_be;
        bit          e_err;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // d64 addr wdata we sz sx gd rvd er rdata | mis be err rdata
        vecs[0]  = '{1'b0, 32'h100, 64'hDEADBEEF, 1'b1, 2'd2, 1'b0, 0, 0, 1'b0, 64'h0,
                     1'b0, 8'h0F, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 32'h103, 64'h0, 1'b0, 2'd0, 1'b1, 0, 0, 1'b0, 64'h80112233,
                     1'b0, 8'h08, 1'b0, 64'hFFFFFF80};
        vecs[2]  = '{1'b0, 32'h103, 64'h0, 1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 64'h80112233,
                     1'b0, 8'h08, 1'b0, 64'h00000080};
        vecs[3]  = '{1'b0, 32'h102, 64'h0, 1'b0, 2'd1, 1'b1, 3, 0, 1'b0, 64'hABCD0000,
                     1'b0, 8'h0C, 1'b0, 64'hFFFFABCD};
        vecs[4]  = '{1'b0, 32'h101, 64'h0, 1'b0, 2'd2, 1'b1, 0, 0, 1'b0, 64'h0,
                     1'b1, 8'h00, 1'b0, 64'hFFFFABCD};
        vecs[5]  = '{1'b0, 32'h104, 64'h0, 1'b0, 2'd2, 1'b0, 0, -1, 1'b0, 64'h0,
                     1'b0, 8'h0F, 1'b1, 64'hFFFFABCD};
        vecs[6]  = '{1'b0, 32'h108, 64'h0, 1'b0, 2'd2, 1'b0, 1, 1, 1'b1, 64'h12345678,
                     1'b0, 8'h0F, 1'b1, 64'hFFFFABCD};
        vecs[7]  = '{1'b0, 32'h10C, 64'h0, 1'b0, 2'd2, 1'b0, 0, 3, 1'b0, 64'h12345678,
                     1'b0, 8'h0F, 1'b0, 64'h12345678};
        vecs[8]  = '{1'b0, 32'h110, 64'h0, 1'b0, 2'd3, 1'b0, 0, 0, 1'b0, 64'h0,
                     1'b1, 8'h00, 1'b0, 64'h12345678};
        vecs[9]  = '{1'b0, 32'h106, 64'h0, 1'b0, 2'd1, 1'b0, 0, 2, 1'b0, 64'h80015555,
                     1'b0, 8'h0C, 1'b0, 64'h00008001};
        vecs[10] = '{1'b0, 32'h201, 64'hA5, 1'b1, 2'd0, 1'b0, 1, 0, 1'b0, 64'h0,
                     1'b0, 8'h02, 1'b0, 64'h00008001};
        vecs[11] = '{1'b0, 32'h203, 64'h1234, 1'b1, 2'd1, 1'b0, 0, 0, 1'b0, 64'h0,
                     1'b1, 8'h00, 1'b0, 64'h00008001};
        vecs[12] = '{1'b0, 32'h204, 64'hCAFE, 1'b1, 2'd1, 1'b0, 0, 0, 1'b1, 64'h0,
                     1'b0, 8'h03, 1'b1, 64'h00008001};
        vecs[13] = '{1'b1, 32'h008, 64'h0, 1'b0, 2'd3, 1'b0, 0, 0, 1'b0, 64'h8877665544332211,
                     1'b0, 8'hFF, 1'b0, 64'h8877665544332211};
        vecs[14] = '{1'b1, 32'h00F, 64'h0, 1'b0, 2'd0, 1'b1, 1, 2, 1'b0, 64'h80AABBCCDDEEFF11,
                     1'b0, 8'h80, 1'b0, 64'hFFFFFFFFFFFFFF80};
        vecs[15] = '{1'b1, 32'h014, 64'h0, 1'b0, 2'd2, 1'b1, 0, 0, 1'b0, 64'h9ABCDEF012345678,
                     1'b0, 8'hF0, 1'b0, 64'hFFFFFFFF9ABCDEF0};
        vecs[16] = '{1'b1, 32'h00C, 64'h0, 1'b0, 2'd3, 1'b0, 0, 0, 1'b0, 64'h0,
                     1'b1, 8'h00, 1'b0, 64'hFFFFFFFF9ABCDEF0};
        vecs[17] = '{1'b1, 32'h018, 64'h1122334455667788, 1'b1, 2'd3, 1'b0, 0, 7, 1'b0, 64'h0,
                     1'b0, 8'hFF, 1'b0, 64'hFFFFFFFF9ABCDEF0};

        rst_n = 1'b0; valid32 = 1'b0; valid64 = 1'b0;
        addr = 32'd0; wdata = 64'd0; we = 1'b0; size = 2'd0; sext = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; mrdata = 64'd0; sel64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset("reset32");
        sel64 = 1'b1;
        #1;
        chk_reset("reset64");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            run_txn(vecs[i].d64, vecs[i].a, vecs[i].wd, vecs[i].w, vecs[i].sz, vecs[i].sx,
                    vecs[i].gd, vecs[i].rvd, vecs[i].er, vecs[i].rd, vecs[i].e_mis,
                    vecs[i].e_be, vecs[i].e_err, vecs[i].e_rdata, $sformatf("vec%0d", i));
        end

        // Reset while waiting for a response; a late response must be dropped.
        sel64 = 1'b0;
        addr = 32'h300; we = 1'b0; size = 2'd2; sext = 1'b0; merr = 1'b0;
        mrdata = 64'h5555AAAA;
        valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset("midrst32");
        sel64 = 1'b1;
        #1;
        chk_reset("midrst64");
        sel64 = 1'b0;
        tick();
        rst_n = 1'b1;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        #1;
        chk1("midrst_drop", "done", x_done, 1'b0);
        chk1("midrst_drop", "ready", x_ready, 1'b1);
        chk64("midrst_drop", "rdata", x_rdata, 64'd0);
        prev32 = 64'd0;
        prev64 = 64'd0;
        $display("txn midrst addr=0x300 errors=%0d", n_errors);

        // Random accesses against the reference model.
        for (int n = 0; n < 60; n++) begin
            bit          d64;
            logic [31:0] a;
            logic [1:0]  sz;
            bit          w, sx, er, mis, tout, e_err;
            int          gd, rvd, nb;
            logic [63:0] wd, rd, e_rd;
            d64 = (n % 4 == 3);
            nb = d64 ? 8 : 4;
            sz = 2'($urandom_range(0, 3));
            a = 32'h2000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            w = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            er = ($urandom_range(0, 7) == 0);
            gd = int'($urandom_range(0, 3));
            rvd = int'($urandom_range(0, 5));
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            mis = m_mis(a, sz, nb);
            tout = !d64 && (rvd >= 4);
            e_err = !mis && (tout || er);
            if (mis || w || e_err) e_rd = d64 ? prev64 : prev32;
            else e_rd = m_load(rd, a, sz, sx, nb);
            run_txn(d64, a, wd, w, sz, sx, gd, rvd, er, rd, mis, mis ? 8'h00 : m_be(a, sz, nb),
                    e_err, e_rd, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
